axi_burst_mover: RTL and testbench

- Parametrised successor of the single-word DRAM/SD bridge datapath. Moves 1..DEPTH consecutive DATA_W-bit words between DRAM and a local word buffer. DRAM is reached over single-beat AXI-style channels (AR/R, AW/W/B).
- After a transfer completes, it replays the moved words as a byte stream on out_valid/out_data.
- Sits between the top-level command decoder and the pseudo DRAM model.
- Adds multi-word requests, response checking and a watchdog timeout.

---
 rtl/axi_burst_mover.sv | 191 +++++++++++++++++++
 tb/tb_axi_burst_mover.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mover.sv
// axi_burst_mover: moves 1..DEPTH consecutive words between DRAM and a local
// word buffer over single-beat AXI-style channels. After a successful transfer,
// it replays the buffer as a byte stream, word 0 first and MSB byte first.
// Handshake rule on every channel: a transfer happens on a rising clk edge where
// VALID and READY are both 1. This block holds its VALID and payload stable
// until that edge and drops VALID in the following cycle.
module axi_burst_mover #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     direction,
  input  logic [ADDR_W-1:0]        addr_dram,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic                     wd_valid,
  input  logic [DATA_W-1:0]        wd_data,
  output logic                     wd_ready,
  output logic                     AR_VALID,
  output logic [31:0]              AR_ADDR,
  input  logic                     AR_READY,
  input  logic                     R_VALID,
  input  logic [DATA_W-1:0]        R_DATA,
  input  logic [1:0]               R_RESP,
  output logic                     R_READY,
  output logic                     AW_VALID,
  output logic [31:0]              AW_ADDR,
  input  logic                     AW_READY,
  output logic                     W_VALID,
  output logic [DATA_W-1:0]        W_DATA,
  input  logic                     W_READY,
  input  logic                     B_VALID,
  input  logic [1:0]               B_RESP,
  output logic                     B_READY,
  output logic                     busy,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     err_valid,
  output logic [3:0]               dbg_state
);

  localparam int LW    = $clog2(DEPTH);
  localparam int BYTES = DATA_W / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_AR   = 4'd2;
  localparam logic [3:0] S_R    = 4'd3;
  localparam logic [3:0] S_AW   = 4'd4;
  localparam logic [3:0] S_W    = 4'd5;
  localparam logic [3:0] S_B    = 4'd6;
  localparam logic [3:0] S_OUT  = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic [3:0]        state, state_n;
  logic [LW-1:0]     n_m1;       // word count minus one
  logic [LW-1:0]     idx;        // current word index (load index in LOAD)
  logic [ADDR_W-1:0] word_addr;  // DRAM address of word idx, wraps naturally
  logic [WDW-1:0]    wd_cnt;     // cycles spent in the current waiting state
  logic [LW-1:0]     ow, ow_n;   // word index of the byte on out_data
  logic [BW-1:0]     obb, obb_n; // byte index within that word
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] src_word, src_shift;
  logic [7:0]        out_byte;
  logic              waiting, wd_hit, out_last;

  assign AR_ADDR   = 32'(word_addr);
  assign AW_ADDR   = 32'(word_addr);
  assign dbg_state = state;

  assign waiting  = (state == S_AR) || (state == S_R) || (state == S_AW) ||
                    (state == S_W)  || (state == S_B);
  assign wd_hit   = (wd_cnt == WDW'(TIMEOUT - 1));
  assign out_last = (ow == n_m1) && (obb == BW'(BYTES - 1));

  // Next-state logic; a handshake always wins over the watchdog in its cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (in_valid) state_n = direction ? S_LOAD : S_AR;
      S_LOAD: if (wd_valid && wd_ready && (idx == n_m1)) state_n = S_AW;
      S_AR:   if (AR_READY) state_n = S_R;
              else if (wd_hit) state_n = S_ERR;
      S_R:    if (R_VALID) begin
                if (R_RESP != 2'd0)   state_n = S_ERR;
                else if (idx == n_m1) state_n = S_OUT;
                else                  state_n = S_AR;
              end else if (wd_hit) state_n = S_ERR;
      S_AW:   if (AW_READY) state_n = S_W;
              else if (wd_hit) state_n = S_ERR;
      S_W:    if (W_READY) state_n = S_B;
              else if (wd_hit) state_n = S_ERR;
      S_B:    if (B_VALID) begin
                if (B_RESP != 2'd0)   state_n = S_ERR;
                else if (idx == n_m1) state_n = S_OUT;
                else                  state_n = S_AW;
              end else if (wd_hit) state_n = S_ERR;
      S_OUT:  if (out_last) state_n = S_IDLE;
      S_ERR:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Select the next stream byte; the final read beat of a one-word read is
  // forwarded because it lands in the buffer on the same edge OUT starts.
  always_comb begin
    ow_n  = '0;
    obb_n = '0;
    if (state == S_OUT) begin
      if (obb == BW'(BYTES - 1)) begin
        ow_n  = ow + 1'b1;
        obb_n = '0;
      end else begin
        ow_n  = ow;
        obb_n = obb + 1'b1;
      end
    end
    src_word  = ((state == S_R) && (idx == '0)) ? R_DATA : mem[ow_n];
    src_shift = src_word >> (8 * (BYTES - 1 - int'(obb_n)));
    out_byte  = src_shift[7:0];
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_m1      <= '0;
      idx       <= '0;
      word_addr <= '0;
      wd_cnt    <= '0;
      ow        <= '0;
      obb       <= '0;
      wd_ready  <= 1'b0;
      AR_VALID  <= 1'b0;
      R_READY   <= 1'b0;
      AW_VALID  <= 1'b0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      B_READY   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      err_valid <= 1'b0;
    end else begin
      state  <= state_n;
      wd_cnt <= (waiting && (state_n == state)) ? wd_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (in_valid) begin
                  n_m1      <= len;
                  word_addr <= addr_dram;
                  idx       <= '0;
                end
        S_LOAD: if (wd_valid && wd_ready) idx <= (idx == n_m1) ? '0 : idx + 1'b1;
        S_R:    if (R_VALID && (R_RESP == 2'd0) && (idx != n_m1)) begin
                  idx       <= idx + 1'b1;
                  word_addr <= word_addr + 1'b1;
                end
        S_B:    if (B_VALID && (B_RESP == 2'd0) && (idx != n_m1)) begin
                  idx       <= idx + 1'b1;
                  word_addr <= word_addr + 1'b1;
                end
        default: ;
      endcase
      if ((state == S_AW) && (state_n == S_W)) W_DATA <= mem[idx];
      ow        <= (state_n == S_OUT) ? ow_n  : '0;
      obb       <= (state_n == S_OUT) ? obb_n : '0;
      wd_ready  <= (state_n == S_LOAD);
      AR_VALID  <= (state_n == S_AR);
      R_READY   <= (state_n == S_R);
      AW_VALID  <= (state_n == S_AW);
      W_VALID   <= (state_n == S_W);
      B_READY   <= (state_n == S_B);
      busy      <= (state_n != S_IDLE);
      err_valid <= (state_n == S_ERR);
      out_valid <= (state_n == S_OUT);
      out_data  <= (state_n == S_OUT) ? out_byte : 8'h00;
    end
  end

  // Word buffer: filled from the write-data port in LOAD or from R beats.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && wd_valid && wd_ready) mem[idx] <= wd_data;
    if ((state == S_R) && R_VALID)                 mem[idx] <= R_DATA;
  end

endmodule

// File: tb/tb_axi_burst_mover.sv
// Bench for axi_burst_mover: a pseudo DRAM slave with random stalls, a byte
// scoreboard fed when requests are issued, and one task per scenario.
module tb_axi_burst_mover;
  localparam int DW = 64;
  localparam int A_W = 14;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, direction = 1'b0;
  logic [A_W-1:0] addr_dram = '0;
  logic [2:0] len = '0;
  logic wd_valid = 1'b0;
  logic [DW-1:0] wd_data = '0;
  logic wd_ready;
  logic AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
  logic W_VALID, W_READY, B_VALID, B_READY;
  logic [31:0] AR_ADDR, AW_ADDR;
  logic [DW-1:0] R_DATA, W_DATA;
  logic [1:0] R_RESP, B_RESP;
  logic busy, out_valid, err_valid;
  logic [7:0] out_data;
  logic [3:0] dbg_state;
  logic [148:0] outs_vec;

  always #5 clk = ~clk;

  axi_burst_mover #(.DATA_W(DW), .ADDR_W(A_W), .DEPTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .direction(direction),
    .addr_dram(addr_dram), .len(len), .wd_valid(wd_valid), .wd_data(wd_data),
    .wd_ready(wd_ready), .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
    .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .err_valid(err_valid), .dbg_state(dbg_state)
  );

  assign outs_vec = {wd_ready, AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID,
                     W_DATA, B_READY, busy, out_valid, out_data, err_valid, dbg_state};

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [DW-1:0] dram [0:(1<<A_W)-1];
  logic [31:0] ar_log[$];
  logic [31:0] aw_log[$];
  logic [DW-1:0] wr_words [0:7];
  int stall_max = 0, err_beat = -1, rd_beat = 0, aw_block = 0, w_hold = 0;
  int out_cnt = 0, out_first = 0, out_last = 0, err_cnt = 0, aw_hi_cnt = 0, cyc = 0;
  logic [7:0] mon_exp;

  // Output monitor: scoreboard pops, idle-zero and AW/W exclusivity.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (out_valid) begin
          if (out_cnt == 0) out_first = cyc;
          out_last = cyc;
          out_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_extra got %h expected no byte", out_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
              errors++;
              $display("FAIL stream_byte got %h expected %h", out_data, mon_exp);
            end
          end
        end else begin
          checks++;
          if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL out_data_idle got %h expected 00", out_data);
          end
        end
        checks++;
        if (AW_VALID && W_VALID) begin
          errors++;
          $display("FAIL aw_w_overlap got both valid expected exclusive");
        end
        if (err_valid) err_cnt++;
        if (AW_VALID) aw_hi_cnt++;
      end
    end
  end

  // Read-side DRAM slave.
  initial begin
    AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = '0; R_RESP = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n && AR_VALID) begin
        logic [31:0] a;
        int n;
        bit ab, hs;
        a = AR_ADDR; ab = 1'b0;
        n = $urandom_range(0, stall_max);
        for (int j = 0; j < n; j++) begin
          @(negedge clk);
          if (!AR_VALID) begin ab = 1'b1; break; end
          checks++;
          if (AR_ADDR !== a) begin
            errors++;
            $display("FAIL ar_addr_stable got %0d expected %0d", AR_ADDR, a);
          end
        end
        if (!ab) begin
          AR_READY = 1'b1; ar_log.push_back(a);
          @(negedge clk);
          AR_READY = 1'b0;
          n = $urandom_range(0, stall_max);
          for (int j = 0; j < n; j++) @(negedge clk);
          R_VALID = 1'b1; R_DATA = dram[a[A_W-1:0]];
          R_RESP = (rd_beat == err_beat) ? 2'd2 : 2'd0;
          rd_beat++;
          for (int j = 0; j < 50; j++) begin
            hs = R_READY;
            @(negedge clk);
            if (hs) break;
          end
          R_VALID = 1'b0; R_RESP = 2'd0; R_DATA = '0;
        end
      end
    end
  end

  // Write-side DRAM slave; abandons a transaction if the DUT drops VALID.
  initial begin
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n && AW_VALID) begin
        logic [31:0] a;
        int n;
        bit ab, hs;
        a = AW_ADDR; ab = 1'b0;
        n = (aw_block != 0) ? 1100 : $urandom_range(0, stall_max);
        for (int j = 0; j < n; j++) begin
          @(negedge clk);
          if (!AW_VALID) begin ab = 1'b1; break; end
        end
        if (!ab) begin
          AW_READY = 1'b1; aw_log.push_back(a);
          @(negedge clk);
          AW_READY = 1'b0;
          ab = 1'b1;
          for (int j = 0; j < 10; j++) begin
            if (W_VALID) begin ab = 1'b0; break; end
            @(negedge clk);
          end
          if (!ab) begin
            n = (w_hold != 0) ? w_hold : $urandom_range(0, stall_max);
            for (int j = 0; j < n; j++) begin
              @(negedge clk);
              if (!W_VALID) begin ab = 1'b1; break; end
            end
            if (!ab) begin
              W_READY = 1'b1; dram[a[A_W-1:0]] = W_DATA;
              @(negedge clk);
              W_READY = 1'b0;
              n = $urandom_range(0, stall_max);
              for (int j = 0; j < n; j++) @(negedge clk);
              B_VALID = 1'b1; B_RESP = 2'd0;
              for (int j = 0; j < 50; j++) begin
                hs = B_READY;
                @(negedge clk);
                if (hs) break;
              end
              B_VALID = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic start_req(input logic dir, input logic [A_W-1:0] a, input logic [2:0] l);
    @(negedge clk);
    in_valid = 1'b1; direction = dir; addr_dram = a; len = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed_words(input int n);
    int k = 0;
    int g = 0;
    bit hs;
    while (k < n && g < 200) begin
      wd_valid = ($urandom_range(0, 3) != 0);
      wd_data  = wr_words[k];
      hs = wd_valid && wd_ready;
      @(negedge clk);
      if (hs) k++;
      g++;
    end
    wd_valid = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL load_words got %0d accepted expected %0d", k, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle busy still 1 after %0d cycles expected 0", name, budget);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int b = 7; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic clear_stats();
    out_cnt = 0; err_cnt = 0; aw_hi_cnt = 0; rd_beat = 0;
    ar_log.delete(); aw_log.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", outs_vec);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got %h expected 0", outs_vec);
    end
  endtask

  task automatic test_read_single();
    clear_stats();
    stall_max = 0;
    dram[5] = 64'h0123_4567_89AB_CDEF;
    push_word(dram[5]);
    start_req(1'b0, 14'd5, 3'd0);
    wait_idle(200, "read_single");
    checks++;
    if (ar_log.size() != 1 || ar_log[0] !== 32'd5) begin
      errors++;
      $display("FAIL read_single_ar got %0d reqs first %0d expected 1 req at 5",
               ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hFFFFFFFF);
    end
    checks++;
    if (out_cnt != 8 || (out_last - out_first + 1) != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_single_stream got %0d bytes span %0d left %0d expected 8 8 0",
               out_cnt, out_last - out_first + 1, exp_q.size());
    end
    checks++;
    if (err_cnt != 0) begin
      errors++;
      $display("FAIL read_single_err got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_write_wrap();
    clear_stats();
    stall_max = 3;
    for (int i = 0; i < 3; i++) begin
      wr_words[i] = {$urandom, $urandom};
      push_word(wr_words[i]);
    end
    start_req(1'b1, 14'd16383, 3'd2);
    feed_words(3);
    wait_idle(500, "write_wrap");
    checks++;
    if (aw_log.size() != 3) begin
      errors++;
      $display("FAIL write_wrap_aw_count got %0d expected 3", aw_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (aw_log[i] !== 32'((16383 + i) % 16384)) begin
          errors++;
          $display("FAIL write_wrap_aw_addr got %0d expected %0d", aw_log[i], (16383 + i) % 16384);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dram[(16383 + i) % 16384] !== wr_words[i]) begin
        errors++;
        $display("FAIL write_wrap_dram got %h expected %h", dram[(16383 + i) % 16384], wr_words[i]);
      end
    end
    checks++;
    if (out_cnt != 24 || (out_last - out_first + 1) != 24 || exp_q.size() != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL write_wrap_stream got %0d bytes left %0d errs %0d expected 24 0 0",
               out_cnt, exp_q.size(), err_cnt);
    end
  endtask

  task automatic test_read_stalls();
    int base;
    clear_stats();
    stall_max = 20;
    base = $urandom_range(0, 16383);
    for (int i = 0; i < 8; i++) begin
      dram[(base + i) % 16384] = {$urandom, $urandom};
      push_word(dram[(base + i) % 16384]);
    end
    start_req(1'b0, 14'(base), 3'd7);
    wait_idle(2500, "read_stalls");
    checks++;
    if (ar_log.size() != 8) begin
      errors++;
      $display("FAIL read_stalls_ar_count got %0d expected 8", ar_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ar_log[i] !== 32'((base + i) % 16384)) begin
          errors++;
          $display("FAIL read_stalls_ar_addr got %0d expected %0d", ar_log[i], (base + i) % 16384);
        end
      end
    end
    checks++;
    if (out_cnt != 64 || (out_last - out_first + 1) != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_stalls_stream got %0d bytes left %0d expected 64 0", out_cnt, exp_q.size());
    end
  endtask

  task automatic test_read_error();
    clear_stats();
    stall_max = 2;
    err_beat = 1;
    for (int i = 0; i < 3; i++) dram[100 + i] = {$urandom, $urandom};
    start_req(1'b0, 14'd100, 3'd2);
    wait_idle(300, "read_error");
    err_beat = -1;
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL read_error_pulse got %0d cycles expected 1", err_cnt);
    end
    checks++;
    if (out_cnt != 0) begin
      errors++;
      $display("FAIL read_error_no_stream got %0d bytes expected 0", out_cnt);
    end
    checks++;
    if (ar_log.size() != 2) begin
      errors++;
      $display("FAIL read_error_ar_count got %0d expected 2", ar_log.size());
    end
  endtask

  task automatic test_timeout();
    clear_stats();
    stall_max = 0;
    aw_block = 1;
    wr_words[0] = {$urandom, $urandom};
    start_req(1'b1, 14'd200, 3'd0);
    feed_words(1);
    wait_idle(1500, "timeout");
    aw_block = 0;
    checks++;
    if (aw_hi_cnt != TO) begin
      errors++;
      $display("FAIL timeout_aw_cycles got %0d expected %0d", aw_hi_cnt, TO);
    end
    checks++;
    if (err_cnt != 1 || out_cnt != 0 || aw_log.size() != 0) begin
      errors++;
      $display("FAIL timeout_abort got err %0d bytes %0d aw %0d expected 1 0 0",
               err_cnt, out_cnt, aw_log.size());
    end
    checks++;
    if (AW_VALID !== 1'b0) begin
      errors++;
      $display("FAIL timeout_aw_drop got %b expected 0", AW_VALID);
    end
    clear_stats();
    dram[300] = {$urandom, $urandom};
    push_word(dram[300]);
    start_req(1'b0, 14'd300, 3'd0);
    wait_idle(200, "timeout_next");
    checks++;
    if (out_cnt != 8 || exp_q.size() != 0 || ar_log.size() != 1) begin
      errors++;
      $display("FAIL timeout_next_req got %0d bytes left %0d ar %0d expected 8 0 1",
               out_cnt, exp_q.size(), ar_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [DW-1:0] sentinel;
    clear_stats();
    stall_max = 0;
    w_hold = 12;
    sentinel = {$urandom, $urandom};
    dram[50] = sentinel;
    for (int i = 0; i < 2; i++) wr_words[i] = {$urandom, $urandom};
    start_req(1'b1, 14'd50, 3'd1);
    feed_words(2);
    c = 0;
    while (!W_VALID && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!W_VALID) begin
      errors++;
      $display("FAIL reset_mid_reach_w got W_VALID 0 expected 1");
    end
    start_req(1'b0, 14'd7, 3'd0);
    checks++;
    if (dbg_state !== 4'd5 || AR_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ignore got state %0d ar %b expected 5 0", dbg_state, AR_VALID);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got %h expected 0", outs_vec);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w_hold = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ar_log.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got busy %b ar %0d expected 0 0", busy, ar_log.size());
    end
    checks++;
    if (dram[50] !== sentinel) begin
      errors++;
      $display("FAIL reset_mid_no_write got %h expected %h", dram[50], sentinel);
    end
    clear_stats();
    dram[60] = {$urandom, $urandom};
    dram[61] = {$urandom, $urandom};
    push_word(dram[60]);
    push_word(dram[61]);
    start_req(1'b0, 14'd60, 3'd1);
    wait_idle(300, "reset_mid_next");
    checks++;
    if (out_cnt != 16 || exp_q.size() != 0 || ar_log.size() != 2 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_next got %0d bytes left %0d ar %0d err %0d expected 16 0 2 0",
               out_cnt, exp_q.size(), ar_log.size(), err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_write_wrap();
    test_read_stalls();
    test_read_error();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
